// File: rtl/bit_stream_sequencer.sv
// Feeds the consecutive-bit detector from a manual bit FIFO or a loaded playback pattern, and counts detections.
// Latency: play_start -> first pulse 1 cycle; manual bit into an idle, empty FIFO -> pulse 2 cycles; pulses GAP_CYCLES+1 apart.
// Backpressure: none upstream; a manual entry arriving while the FIFO is full (and not popping) is discarded with drop.
module bit_stream_sequencer #(
    parameter int GAP_CYCLES = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PAT_LEN    = 8,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_zero,
    input  logic               in_one,
    input  logic               play_start,
    input  logic               play_abort,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               detected_00,
    input  logic               detected_11,
    input  logic               clr_cnt,
    output logic               btn0_pulse,
    output logic               btn2_pulse,
    output logic [CNT_W-1:0]   cnt_00,
    output logic [CNT_W-1:0]   cnt_11,
    output logic               busy,
    output logic               fifo_full,
    output logic               drop
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    typedef enum logic {MAN, PLAY} src_t;

    state_t             state;
    src_t               src;
    logic [IW-1:0]      idx;
    logic [PAT_LEN-1:0] shreg;
    logic [GW-1:0]      gap_cnt;

    logic               mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count, count_nxt;

    logic fifo_ne, head, gap_done, abort, pop, push_req, push, drop_nxt, to_idle;
    logic d00_q, d11_q;

    assign fifo_ne  = (count != '0);
    assign head     = mem[rd_ptr];
    assign gap_done = (state == GAP) && (gap_cnt == GW'(1));
    assign abort    = play_abort && (src == PLAY) && (state != IDLE);
    // The FSM pops before the push is judged, so a full FIFO still accepts a push in a popping cycle.
    assign pop      = fifo_ne && (((state == IDLE) && !play_start) || (gap_done && (src == MAN)));
    assign push_req = in_zero ^ in_one;
    assign push     = push_req && ((count != FULL_CNT) || pop);
    assign drop_nxt = (in_zero && in_one) || (push_req && !push);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        to_idle = 1'b0;
        case (state)
            IDLE:    to_idle = !play_start && !fifo_ne;
            ISSUE:   to_idle = abort;
            GAP:     to_idle = abort || (gap_done && !((src == PLAY) && (idx != '0))
                                                  && !((src == MAN) && fifo_ne));
            default: to_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_one;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Pulses are set on entry to ISSUE so they are high for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src        <= MAN;
            idx        <= '0;
            shreg      <= '0;
            gap_cnt    <= '0;
            btn0_pulse <= 1'b0;
            btn2_pulse <= 1'b0;
            busy       <= 1'b0;
            fifo_full  <= 1'b0;
            drop       <= 1'b0;
        end else begin
            btn0_pulse <= 1'b0;
            btn2_pulse <= 1'b0;
            busy       <= !to_idle || (count_nxt != '0);
            fifo_full  <= (count_nxt == FULL_CNT);
            drop       <= drop_nxt;
            case (state)
                IDLE: begin
                    if (play_start) begin
                        shreg      <= pattern;
                        idx        <= IW'(PAT_LEN - 1);
                        src        <= PLAY;
                        state      <= ISSUE;
                        btn2_pulse <= pattern[PAT_LEN-1];
                        btn0_pulse <= !pattern[PAT_LEN-1];
                    end else if (fifo_ne) begin
                        src        <= MAN;
                        state      <= ISSUE;
                        btn2_pulse <= head;
                        btn0_pulse <= !head;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GW'(GAP_CYCLES);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!gap_done) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if ((src == PLAY) && (idx != '0)) begin
                        idx        <= idx - 1'b1;
                        shreg      <= {shreg[PAT_LEN-2:0], 1'b0};
                        state      <= ISSUE;
                        btn2_pulse <= shreg[PAT_LEN-2];
                        btn0_pulse <= !shreg[PAT_LEN-2];
                    end else if ((src == MAN) && fifo_ne) begin
                        state      <= ISSUE;
                        btn2_pulse <= head;
                        btn0_pulse <= !head;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d00_q  <= 1'b0;
            d11_q  <= 1'b0;
            cnt_00 <= '0;
            cnt_11 <= '0;
        end else begin
            d00_q <= detected_00;
            d11_q <= detected_11;
            if (clr_cnt)
                cnt_00 <= '0;
            else if (detected_00 && !d00_q && (cnt_00 != CNT_MAX))
                cnt_00 <= cnt_00 + 1'b1;
            if (clr_cnt)
                cnt_11 <= '0;
            else if (detected_11 && !d11_q && (cnt_11 != CNT_MAX))
                cnt_11 <= cnt_11 + 1'b1;
        end
    end
endmodule

// File: tb/tb_bit_stream_sequencer.sv
// Scoreboard bench: a queue-based reference model predicts each pulse (bit and cycle) and the status outputs.
module tb_bit_stream_sequencer;
    localparam int GAP   = 3;
    localparam int DEPTH = 4;
    localparam int PL    = 8;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          clk = 1'b0, reset = 1'b0;
    logic          in_zero = 1'b0, in_one = 1'b0, play_start = 1'b0, play_abort = 1'b0;
    logic          detected_00 = 1'b0, detected_11 = 1'b0, clr_cnt = 1'b0;
    logic [PL-1:0] pattern = '0;
    logic          btn0_pulse, btn2_pulse, busy, fifo_full, drop;
    logic [CW-1:0] cnt_00, cnt_11;

    int vectors = 0, miscompares = 0, cyc = 0;

    bit_stream_sequencer #(.GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .PAT_LEN(PL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_zero(in_zero), .in_one(in_one),
        .play_start(play_start), .play_abort(play_abort), .pattern(pattern),
        .detected_00(detected_00), .detected_11(detected_11), .clr_cnt(clr_cnt),
        .btn0_pulse(btn0_pulse), .btn2_pulse(btn2_pulse), .cnt_00(cnt_00), .cnt_11(cnt_11),
        .busy(busy), .fifo_full(fifo_full), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct { bit b; int c; } ev_t;
    ev_t sbq[$];
    bit  mq[$];
    bit  pq[$];
    int  mode = 0;   // 0 idle, 1 manual, 2 playback
    int  timer = 0;
    bit  e_busy = 0, e_full = 0, e_drop = 0, p00 = 0, p11 = 0;
    int  e_c00 = 0, e_c11 = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void issue(input bit b);
        ev_t e;
        e.b = b;
        e.c = cyc;
        sbq.push_back(e);
        timer = GAP + 1;
    endfunction

    // Reference model: queues of pending bits, a countdown to the next allowed pulse.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete(); pq.delete(); sbq.delete();
            mode = 0; timer = 0;
            e_busy = 0; e_full = 0; e_drop = 0; p00 = 0; p11 = 0; e_c00 = 0; e_c11 = 0;
        end else begin
            cyc++;
            if (mode == 0) begin
                if (play_start) begin
                    pq.delete();
                    for (int i = PL - 1; i >= 0; i--) pq.push_back(pattern[i]);
                    mode = 2;
                    issue(pq.pop_front());
                end else if (mq.size() > 0) begin
                    mode = 1;
                    issue(mq.pop_front());
                end
            end else if (play_abort && mode == 2) begin
                mode = 0;
                pq.delete();
            end else begin
                timer--;
                if (timer == 0) begin
                    if (mode == 2 && pq.size() > 0) issue(pq.pop_front());
                    else if (mode == 1 && mq.size() > 0) issue(mq.pop_front());
                    else mode = 0;
                end
            end
            e_drop = 0;
            if (in_zero && in_one) e_drop = 1;
            else if (in_zero || in_one) begin
                if (mq.size() < DEPTH) mq.push_back(in_one);
                else e_drop = 1;
            end
            e_busy = (mode != 0) || (mq.size() > 0);
            e_full = (mq.size() == DEPTH);
            if (clr_cnt) e_c00 = 0; else if (detected_00 && !p00 && e_c00 < CMAX) e_c00++;
            if (clr_cnt) e_c11 = 0; else if (detected_11 && !p11 && e_c11 < CMAX) e_c11++;
            p00 = detected_00;
            p11 = detected_11;
        end
    end

    // Monitor: compares on the falling edge, popping the scoreboard whenever a pulse appears.
    always @(negedge clk) begin
        if (reset) begin
            if (btn0_pulse || btn2_pulse) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", int'(btn0_pulse | btn2_pulse), 0);
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    chk("pulse_bit", int'(btn2_pulse), int'(e.b));
                    chk("pulse_cycle", cyc, e.c);
                    chk("pulse_exclusive", int'(btn0_pulse & btn2_pulse), 0);
                end
            end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
                chk("missed_pulse", int'(btn0_pulse | btn2_pulse), 1);
                void'(sbq.pop_front());
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("fifo_full", int'(fifo_full), int'(e_full));
            chk("drop", int'(drop), int'(e_drop));
            chk("cnt_00", int'(cnt_00), e_c00);
            chk("cnt_11", int'(cnt_11), e_c11);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_btn0"}, int'(btn0_pulse), 0);
        chk({tag, "_btn2"}, int'(btn2_pulse), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_full"}, int'(fifo_full), 0);
        chk({tag, "_drop"}, int'(drop), 0);
        chk({tag, "_c00"}, int'(cnt_00), 0);
        chk({tag, "_c11"}, int'(cnt_11), 0);
    endtask

    initial begin
        bit bits5 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        // Single manual bit into an idle sequencer
        repeat (6) step();
        in_one = 1'b1; step(); in_one = 1'b0;
        repeat (8) step();
        chk("t1_idle_busy", int'(busy), 0);

        // Fixed playback pattern
        pattern = 8'b1001_1100;
        play_start = 1'b1; step(); play_start = 1'b0;
        repeat (33) step();
        chk("t2_idle_busy", int'(busy), 0);

        // Manual entries during playback: fifth one overflows
        pattern = PL'($urandom);
        play_start = 1'b1; step(); play_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_one = bits5[i]; in_zero = !bits5[i];
            step();
            in_one = 1'b0; in_zero = 1'b0;
            if (i == 4) begin
                chk("t3_drop5", int'(drop), 1);
                chk("t3_full", int'(fifo_full), 1);
            end
            step();
        end
        repeat (60) step();

        // Abort right after the third playback pulse
        pattern = 8'b1010_0110;
        play_start = 1'b1; step(); play_start = 1'b0;
        repeat (8) step();
        play_abort = 1'b1; step(); play_abort = 1'b0;
        chk("t4_abort_busy", int'(busy), 0);
        repeat (6) step();
        play_start = 1'b1; step(); play_start = 1'b0;
        repeat (34) step();

        // Detection counters: edges, saturation, clear-wins
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        detected_00 = 1'b1; repeat (3) step();
        detected_00 = 1'b0; step();
        detected_00 = 1'b1; step(); detected_00 = 1'b0; step();
        detected_00 = 1'b1; step(); detected_00 = 1'b0; step();
        chk("t5_cnt3", int'(cnt_00), 3);
        for (int i = 0; i < 255; i++) begin
            detected_00 = 1'b1; step(); detected_00 = 1'b0; step();
        end
        chk("t5_sat", int'(cnt_00), 255);
        detected_00 = 1'b1; step(); detected_00 = 1'b0; step();
        chk("t5_sat_hold", int'(cnt_00), 255);
        detected_00 = 1'b1; clr_cnt = 1'b1; step();
        detected_00 = 1'b0; clr_cnt = 1'b0;
        chk("t5_clr_edge", int'(cnt_00), 0);
        in_zero = 1'b1; in_one = 1'b1; step();
        in_zero = 1'b0; in_one = 1'b0;
        chk("t5_both_drop", int'(drop), 1);
        repeat (10) step();

        // Asynchronous reset in the middle of playback with FIFO entries pending
        detected_11 = 1'b1; step(); detected_11 = 1'b0;
        pattern = 8'hF0;
        play_start = 1'b1; step(); play_start = 1'b0;
        in_zero = 1'b1; step(); in_zero = 1'b0;
        repeat (4) step();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("t6_async");
        @(negedge clk);
        reset = 1'b1;
        repeat (12) step();
        chk("t6_busy", int'(busy), 0);
        chk("t6_cnt11", int'(cnt_11), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_zero     = ($urandom_range(0, 9) == 0);
            in_one      = ($urandom_range(0, 9) == 0);
            play_start  = ($urandom_range(0, 40) == 0);
            play_abort  = ($urandom_range(0, 60) == 0);
            pattern     = PL'($urandom);
            detected_00 = 1'($urandom_range(0, 1));
            detected_11 = 1'($urandom_range(0, 1));
            clr_cnt     = ($urandom_range(0, 200) == 0);
            step();
        end
        in_zero = 1'b0; in_one = 1'b0; play_start = 1'b0; play_abort = 1'b0;
        detected_00 = 1'b0; detected_11 = 1'b0; clr_cnt = 1'b0;
        repeat (80) step();
        chk("sb_drain", sbq.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_stream_sequencer.md
Name: bit_stream_sequencer

Overview:
- Drives the consecutive-bit detector's btn0_pulse/btn2_pulse inputs from two sources: manual bit entries buffered in a small FIFO, and automatic playback of a loaded PAT_LEN-bit pattern.
- Spaces issued pulses by a fixed gap so the detector sees clean one-cycle strobes.
- Tallies the detector's detected_00/detected_11 events in saturating counters.
- Sits between the board button pulse generators and consecutive_bit_detector_fsm.

Parameters:
GAP_CYCLES, 3, idle cycles after each issued pulse (>=1)
FIFO_DEPTH, 4, manual bit FIFO entries (power of 2, >=2)
PAT_LEN, 8, playback pattern width
CNT_W, 8, detection counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_zero  input  1  one-cycle pulse: enqueue bit 0
in_one  input  1  one-cycle pulse: enqueue bit 1
play_start  input  1  one-cycle pulse: start pattern playback
play_abort  input  1  one-cycle pulse: abort playback
pattern  input  PAT_LEN  playback bits, sampled on accepted play_start, MSB issued first
detected_00  input  1  from detector
detected_11  input  1  from detector
clr_cnt  input  1  synchronous clear of both counters
btn0_pulse  output  1  to detector: bit 0 strobe
btn2_pulse  output  1  to detector: bit 1 strobe
cnt_00  output  CNT_W  count of detected_00 rising edges
cnt_11  output  CNT_W  count of detected_11 rising edges
busy  output  1  FSM not IDLE or FIFO non-empty
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
drop  output  1  one-cycle: a manual entry was discarded

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, FIFO empty, all outputs 0, counters 0, edge-detect registers 0.
- All outputs are registered.
- FIFO push rules:
  - in_zero pushes 0; in_one pushes 1.
  - Both high in the same cycle: nothing pushed, drop=1.
  - Push while full: discarded, drop=1, unless the FSM pops in that same cycle, in which case the push is accepted.
  - Manual pushes are accepted during playback and served after playback ends.
- FSM states: IDLE, ISSUE, GAP. Register src is MAN or PLAY. Registers idx and shreg.
- IDLE:
  - play_start=1: latch shreg=pattern, idx=PAT_LEN-1, src=PLAY, go ISSUE. play_start has priority over a non-empty FIFO.
  - Else if FIFO non-empty: pop, src=MAN, go ISSUE.
- ISSUE (exactly 1 cycle):
  - btn2_pulse=1 if the current bit is 1, else btn0_pulse=1. Never both.
  - Load gap counter with GAP_CYCLES, go GAP.
- GAP, counts down; when the count expires:
  - src=PLAY and idx>0: idx-1, shift shreg, go ISSUE.
  - src=MAN and FIFO non-empty: pop, go ISSUE.
  - Otherwise go IDLE. After playback ends, the FIFO is served from IDLE on the next cycle.
- Pulse spacing: consecutive pulses within one source start exactly GAP_CYCLES+1 cycles apart.
- Latency:
  - play_start sampled at edge k: first pulse high during the cycle after edge k.
  - in_zero/in_one sampled at edge k with FSM IDLE and FIFO empty: pulse high during the cycle after edge k+1.
- play_start while not IDLE: ignored, no side effects.
- play_abort with src=PLAY in ISSUE or GAP: go IDLE at the next edge and discard the remaining pattern bits. A pulse already high completes its single cycle. Ignored when src=MAN or in IDLE.
- Counters:
  - Increment on rising edge of detected_00 / detected_11, i.e. the input is 1 and it was 0 in the previous cycle.
  - Saturate at 2^CNT_W-1.
  - clr_cnt forces 0; clr_cnt and an edge in the same cycle gives 0.
- busy = (state!=IDLE) | (FIFO count!=0).
- fifo_full tracks the registered count.

Test Plan:
1. Reset released, in_one at edge 10 → btn2_pulse=1 for exactly the cycle after edge 11; btn0_pulse stays 0; busy falls after GAP expires (edge 15).
2. play_start at edge k with pattern=8'b1001_1100 → pulse sequence 1,0,0,1,1,1,0,0 starting after edges k, k+4, …, k+28; IDLE and busy=0 after edge k+32.
3. Start playback, then 5 in_zero/in_one pulses on separate cycles during playback → first 4 accepted, fifo_full=1, drop=1 on the 5th; after playback, 4 pulses in push order, 4 cycles apart.
4. play_abort right after the 3rd playback pulse → no further pulses, state IDLE next cycle, busy=0; a subsequent play_start is accepted.
5. detected_00 high for 3 cycles, then two separate 1-cycle pulses → cnt_00=3. Preload to 255 via 255 edges, one more edge → cnt_00 stays 255. clr_cnt coincident with an edge → 0. in_zero and in_one together → drop=1, nothing issued.
6. reset driven low mid-playback between clock edges → outputs 0 immediately; after release, no pulses, FIFO empty, counters 0.
